led_scan_driver: RTL and testbench
==================================

# led_scan_driver

Time-multiplexed driver for the board's 4-digit seven-segment display. It sits directly downstream of the 2-to-1 page selector and consumes its four 8-bit segment patterns. It scans one digit at a time at a programmable slot rate and blanks the display between digits to suppress ghosting. It snapshots all four patterns at each frame boundary so a page switch never tears mid-frame.

## Interface
- `PRESCALE`, default 100000: clock cycles per digit slot; must be ≥ 2.
- `BLANK`, default 1000: cycles blanked at the start of each slot; 0 ≤ `BLANK` < `PRESCALE`.
- `clk`, input, 1: single system clock; all state is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: scan enable. When low, counters freeze and the display is dark.
- `dig0`..`dig3`, input, 8 each: segment patterns, active-high. Bit7 = dp, bits6:0 = g..a. `dig0` is the rightmost digit.
- `an`, output, 4: digit anodes, active-low, registered.
- `seg`, output, 8: segment cathodes, active-low (inverted `dig`), registered.
- `frame_tick`, output, 1: one-cycle pulse marking a new frame and a fresh snapshot.

## Operation
- State:
  - slot counter `cnt`, 0..`PRESCALE`-1, width `$clog2(PRESCALE)`.
  - digit index `idx`, 2 bits.
  - shadow registers `sh0`..`sh3`, 8 bits each.
- Counting (only while `en`=1):
  - `cnt` increments each cycle.
  - At `cnt`=`PRESCALE`-1, `cnt` wraps to 0 and `idx` increments, wrapping 3→0.
- Frame boundary is the cycle with `en`=1, `cnt`=`PRESCALE`-1, `idx`=3. On that edge:
  - `sh0..3` ← `dig0..3`.
  - `frame_tick` is set for one cycle.
- `dig` changes at any other time are ignored until the next frame boundary.
- Output registers, updated every cycle from current state:
  - If `en`=0 or `cnt` < `BLANK`: `an`=4'b1111, `seg`=8'hFF.
  - Otherwise: `an` = ~(4'b0001 << `idx`), `seg` = ~`sh[idx]`.
- Reset values:
  - `cnt`=0, `idx`=0, `sh0..3`=0.
  - `an`=4'hF, `seg`=8'hFF, `frame_tick`=0.
- The first frame after reset scans all-zero shadows: anodes cycle, segments stay off. Real patterns appear after the first `frame_tick`.
- `en` deassert mid-slot:
  - `cnt`/`idx`/shadows hold.
  - The remaining slot time resumes on reassert.
  - No frame boundary occurs while `en`=0.
- Reset mid-operation: all flops clear immediately, without waiting for a clock edge.

## Timing
- `an`/`seg` lag the (`cnt`, `idx`) state by exactly one cycle.
- `frame_tick` is high in the same cycle that `an`/`seg` first reflect the new shadows' slot-0 state. For `BLANK`=0, this is digit 0 with new data.
- Digit slot = `PRESCALE` cycles; frame = 4×`PRESCALE` cycles with `en` held high.
- `frame_tick` period = 4×`PRESCALE` cycles; always exactly one cycle wide.
- Per-digit lit duty = (`PRESCALE`−`BLANK`)/(4×`PRESCALE`).
- With `BLANK`=0, no dark cycles occur between digits.
- `en` takes effect on the next edge: `an`/`seg` go dark one cycle after `en` falls.

## Structure
- Package `led_pkg`: `NUM_DIGITS`=4, `SEG_OFF`=8'hFF, `AN_OFF`=4'hF, and a function returning the one-hot active-low anode for an index.
- Sub-module `scan_prescaler`:
  - Parameters: `PRESCALE`, `BLANK`.
  - Ports: `clk`, `rst_n`, `en`.
  - Outputs: `slot_end` (`cnt`=`PRESCALE`-1 and `en`) and `in_blank` (`cnt` < `BLANK`).
- Top level holds `idx`, the shadows, and the output registers.

## Test plan
All scenarios use `PRESCALE`=4 and `BLANK`=1 unless stated.
- **Reset:** hold `rst_n`=0 for 3 cycles → `an`=F, `seg`=FF, `frame_tick`=0. Release with `en`=1 and `dig0..3`=3F,06,5B,4F → first frame shows `an` cycling 1110/1101/1011/0111 with `seg`=FF throughout. `frame_tick` pulses at cycle 17.
- **Steady scan after the first tick:** per slot, one cycle of `an`=F/`seg`=FF, then 3 cycles of digit 0 (`an`=1110, `seg`=C0), digit 1 (1101, F9), digit 2 (1011, A4), digit 3 (0111, B0).
- **Tear-free update:** change `dig1` to 7F during the digit-2 slot → digit 1 keeps showing F9 for the rest of that frame, and shows 80 only after the next `frame_tick`.
- **Enable gap:** drop `en` on the 2nd lit cycle of digit 0 for 5 cycles → `an`=F/`seg`=FF from the next cycle. On reassert, digit 0 shows for 1 more cycle, then the digit-1 slot begins. The `frame_tick` period stretches by exactly 5.
- **Asynchronous reset mid-slot:** assert `rst_n`=0 between clock edges while digit 2 is lit → `an`=F, `seg`=FF immediately. The first frame after release is dark again.
- **BLANK=0, PRESCALE=2:** no dark cycles between digits; `frame_tick` occurs every 8 cycles and is never 2 cycles wide.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package led_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'hF;

  // One-hot, active-low anode select for digit index idx (0 = rightmost).
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    anode_for = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/led_scan_driver_scan_prescaler.sv
// Slot counter: counts PRESCALE cycles per digit slot while enabled and
// flags the slot's last cycle and its leading blanking window.
module scan_prescaler #(
  parameter int PRESCALE = 100000,
  parameter int BLANK    = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic slot_end,
  output logic in_blank
);

  localparam int              CW      = $clog2(PRESCALE);
  localparam logic [CW-1:0]   CNT_MAX = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_MAX) cnt <= '0;
      else                cnt <= cnt + 1'b1;
    end
  end

  assign slot_end = en && (cnt == CNT_MAX);

  // BLANK = 0 means no dark window; avoid an always-false compare.
  generate
    if (BLANK > 0) begin : g_blank
      localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
      assign in_blank = (cnt < BLANK_C);
    end else begin : g_noblank
      assign in_blank = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with per-slot blanking and
// frame-boundary snapshots so a page change never tears mid-frame.
module led_scan_driver
  import led_pkg::*;
#(
  parameter int PRESCALE = 100000,
  parameter int BLANK    = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] dig0,
  input  logic [7:0] dig1,
  input  logic [7:0] dig2,
  input  logic [7:0] dig3,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       frame_tick
);

  logic       slot_end;
  logic       in_blank;
  logic       frame_end;
  logic       load_d;
  logic [1:0] idx;
  logic [7:0] sh [NUM_DIGITS];

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .slot_end (slot_end),
    .in_blank (in_blank)
  );

  assign frame_end = slot_end && (idx == 2'd3);

  // frame_tick is delayed one extra cycle (via load_d) so it lines up with
  // the first an/seg cycle that shows slot 0 of the freshly loaded shadows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 2'd0;
      for (int i = 0; i < NUM_DIGITS; i++) sh[i] <= 8'h00;
      load_d     <= 1'b0;
      frame_tick <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
    end else begin
      if (slot_end) idx <= idx + 1'b1;
      if (frame_end) begin
        sh[0] <= dig0;
        sh[1] <= dig1;
        sh[2] <= dig2;
        sh[3] <= dig3;
      end
      load_d     <= frame_end;
      frame_tick <= load_d;
      if (!en || in_blank) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end else begin
        an  <= anode_for(idx);
        seg <= ~sh[idx];
      end
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver: two configurations (PRESCALE=4/BLANK=1 and
// PRESCALE=2/BLANK=0) driven in parallel against an elapsed-time model.
module tb_led_scan_driver;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] dig0  = 8'h00;
  logic [7:0] dig1  = 8'h00;
  logic [7:0] dig2  = 8'h00;
  logic [7:0] dig3  = 8'h00;

  int   tests      = 0;
  int   fails      = 0;
  int   cyc        = 0;
  int   dark1      = 0;
  logic checking   = 1'b0;
  logic count_dark = 1'b0;

  // Clock and reset-relative cycle counter
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after the k-th rising edge since reset release.
  task automatic at(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  generate
    for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int P = (g == 0) ? 4 : 2;
      localparam int B = (g == 0) ? 1 : 0;

      logic [3:0] an;
      logic [7:0] seg;
      logic       ft;

      led_scan_driver #(
        .PRESCALE (P),
        .BLANK    (B)
      ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .an         (an),
        .seg        (seg),
        .frame_tick (ft)
      );

      // Model: t = enabled cycles since reset; slot position and digit
      // follow from t by plain division, frames are every 4*P enabled cycles.
      int         t;
      int         pos;
      int         d;
      logic [7:0] msh [4];
      logic [3:0] exp_an;
      logic [7:0] exp_seg;
      logic       exp_ft;
      logic       bnd;
      int         tick_last = 0;
      int         tick_gap  = 0;

      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          t       = 0;
          for (int i = 0; i < 4; i++) msh[i] = 8'h00;
          exp_an  = 4'hF;
          exp_seg = 8'hFF;
          exp_ft  = 1'b0;
          bnd     = 1'b0;
        end else begin
          pos    = t % P;
          d      = (t / P) % 4;
          exp_ft = bnd;
          if (!en || pos < B) begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
          end else begin
            exp_an  = 4'hF ^ (4'b0001 << d);
            exp_seg = ~msh[d];
          end
          bnd = en && ((t % (4 * P)) == (4 * P - 1));
          if (bnd) begin
            msh[0] = dig0;
            msh[1] = dig1;
            msh[2] = dig2;
            msh[3] = dig3;
          end
          if (en) t++;
        end
      end

      always @(posedge clk) begin
        #1;
        if (checking) begin
          chk($sformatf("c%0d_an", g), an, exp_an);
          chk($sformatf("c%0d_seg", g), seg, exp_seg);
          chk($sformatf("c%0d_tick", g), ft, exp_ft);
        end
        if (ft) begin
          tick_gap  = cyc - tick_last;
          tick_last = cyc;
        end
      end
    end
  endgenerate

  always @(posedge clk) begin
    #1;
    if (count_dark && cfg[1].an == 4'hF) dark1++;
  end

  initial begin
    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_an", cfg[0].an, 4'hF);
    chk("rst_seg", cfg[0].seg, 8'hFF);
    chk("rst_tick", cfg[0].ft, 1'b0);

    checking = 1'b1;
    dig0 = 8'h3F; dig1 = 8'h06; dig2 = 8'h5B; dig3 = 8'h4F;
    en = 1'b1;
    rst_n = 1'b1;

    // First frame: anodes cycle, segments dark
    at(2);  chk("f1_an0", cfg[0].an, 4'hE); chk("f1_seg0", cfg[0].seg, 8'hFF);
    at(6);  chk("f1_an1", cfg[0].an, 4'hD); chk("f1_seg1", cfg[0].seg, 8'hFF);
    at(16); chk("f1_an3", cfg[0].an, 4'h7); chk("f1_tick16", cfg[0].ft, 1'b0);
    at(17); chk("f1_tick17", cfg[0].ft, 1'b1); chk("f1_blank17", cfg[0].an, 4'hF);

    // Steady scan with real data
    at(19); chk("s_an0", cfg[0].an, 4'hE); chk("s_seg0", cfg[0].seg, 8'hC0);
    at(23); chk("s_an1", cfg[0].an, 4'hD); chk("s_seg1", cfg[0].seg, 8'hF9);
    at(25); dig1 = 8'h7F;
    at(27); chk("s_an2", cfg[0].an, 4'hB); chk("s_seg2", cfg[0].seg, 8'hA4);
    at(31); chk("s_an3", cfg[0].an, 4'h7); chk("s_seg3", cfg[0].seg, 8'hB0);
    at(33); chk("s_tick33", cfg[0].ft, 1'b1);
    at(38); chk("tear_an1", cfg[0].an, 4'hD); chk("tear_seg1", cfg[0].seg, 8'h80);

    // Enable gap of 5 cycles on the 2nd lit cycle of digit 0
    at(51); chk("gap_pre_an", cfg[0].an, 4'hE); chk("gap_pre_seg", cfg[0].seg, 8'hC0);
    en = 1'b0;
    at(52); chk("gap_dark_an", cfg[0].an, 4'hF); chk("gap_dark_seg", cfg[0].seg, 8'hFF);
    at(56); en = 1'b1;
    at(57); chk("gap_resume_an", cfg[0].an, 4'hE); chk("gap_resume_seg", cfg[0].seg, 8'hC0);
    at(58); chk("gap_next_blank", cfg[0].an, 4'hF);
    at(65); chk("gap_tick65", cfg[0].ft, 1'b0);
    at(70); chk("gap_tick70", cfg[0].ft, 1'b1); chk("gap_period", cfg[0].tick_gap, 21);

    // Asynchronous reset between edges while digit 2 is lit
    at(80); chk("ar_pre_an", cfg[0].an, 4'hB); chk("ar_pre_seg", cfg[0].seg, 8'hA4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_an", cfg[0].an, 4'hF);
    chk("ar_seg", cfg[0].seg, 8'hFF);
    chk("ar_tick", cfg[0].ft, 1'b0);
    chk("ar_an_c1", cfg[1].an, 4'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_dark = 1'b1;

    // Dark first frame again; BLANK=0 config never goes dark
    at(10); chk("ar_f1_an", cfg[0].an, 4'hB); chk("ar_f1_seg", cfg[0].seg, 8'hFF);
    chk("c1_an", cfg[1].an, 4'hE); chk("c1_seg", cfg[1].seg, 8'hC0);
    at(17); chk("ar_tick17", cfg[0].ft, 1'b1);
    at(40);
    count_dark = 1'b0;
    chk("c1_dark", dark1, 0);
    chk("c1_period", cfg[1].tick_gap, 8);
    chk("c1_last_tick", cfg[1].tick_last, 33);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
